iterative_divider: RTL and testbench

- Multicycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU). Computes the inverse of the combinational adder/multiplier path by restoring shift-subtract, one quotient bit per clock.
- Sits beside the ALU in the multicycle and pipelined cores. Control stalls on busy and captures result on result_valid.

---
 rtl/iterative_divider_if.sv | 22 ++
 rtl/iterative_divider.sv | 172 +++++++++++++++++
 tb/tb_iterative_divider.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/iterative_divider_if.sv
// Request/response bundle for iterative_divider: start and operands in, busy and result out.
interface iterative_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       operation;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output start, operation, operand_a, operand_b,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, operation, operand_a, operand_b,
    output busy, result_valid, result
  );
endinterface

// File: rtl/iterative_divider.sv
// RV32M DIV/DIVU/REM/REMU by restoring shift-subtract, one quotient bit per clock.
// Define DIVIDER_EARLY_OUT_EN to finish divide-by-zero and signed overflow directly from IDLE.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  iterative_divider_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] value);
    return ~value + ONE;
  endfunction

  state_t           state_r,  state_next_s;
  logic [WIDTH:0]   rem_r,    rem_next_s;
  logic [WIDTH-1:0] quo_r,    quo_next_s;
  logic [WIDTH-1:0] dvs_r,    dvs_next_s;
  logic [CNT_W-1:0] count_r,  count_next_s;
  logic             is_rem_r, is_rem_next_s;
  logic             q_neg_r,  q_neg_next_s;
  logic             r_neg_r,  r_neg_next_s;
  logic [WIDTH-1:0] result_r, result_next_s;
  logic             valid_r,  valid_next_s;
  logic             busy_r;

  logic             signed_op_s, sign_a_s, sign_b_s, b_zero_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] q_fix_s, r_fix_s;

  assign signed_op_s = ~bus.operation[0];
  assign sign_a_s    = signed_op_s & bus.operand_a[WIDTH-1];
  assign sign_b_s    = signed_op_s & bus.operand_b[WIDTH-1];
  assign b_zero_s    = (bus.operand_b == {WIDTH{1'b0}});
  // The most negative value maps onto itself, which read unsigned is 2^(WIDTH-1).
  assign abs_a_s     = sign_a_s ? negate(bus.operand_a) : bus.operand_a;
  assign abs_b_s     = sign_b_s ? negate(bus.operand_b) : bus.operand_b;

  assign shifted_s   = {rem_r, quo_r[WIDTH-1]};
  assign ge_s        = (shifted_s >= {2'b00, dvs_r});
  assign diff_s      = shifted_s[WIDTH:0] - {1'b0, dvs_r};

  assign q_fix_s     = q_neg_r ? negate(quo_r) : quo_r;
  assign r_fix_s     = r_neg_r ? negate(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];

`ifdef DIVIDER_EARLY_OUT_EN
  logic             overflow_s, special_s;
  logic [WIDTH-1:0] early_result_s;

  assign overflow_s = signed_op_s
                    & (bus.operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                    & (bus.operand_b == {WIDTH{1'b1}});
  assign special_s  = b_zero_s | overflow_s;

  // Architectural result for the two cases that bypass the iteration.
  always_comb begin
    early_result_s = {WIDTH{1'b1}};
    if (b_zero_s) begin
      early_result_s = bus.operation[1] ? bus.operand_a : {WIDTH{1'b1}};
    end else begin
      early_result_s = bus.operation[1] ? {WIDTH{1'b0}} : bus.operand_a;
    end
  end
`endif

  // Next-state and datapath update for IDLE/RUN/FIX.
  always_comb begin
    state_next_s  = state_r;
    rem_next_s    = rem_r;
    quo_next_s    = quo_r;
    dvs_next_s    = dvs_r;
    count_next_s  = count_r;
    is_rem_next_s = is_rem_r;
    q_neg_next_s  = q_neg_r;
    r_neg_next_s  = r_neg_r;
    result_next_s = result_r;
    valid_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          is_rem_next_s = bus.operation[1];
          // A zero divisor yields all-ones naturally; the quotient must not be negated.
          q_neg_next_s  = (sign_a_s ^ sign_b_s) & ~b_zero_s;
          r_neg_next_s  = sign_a_s;
          rem_next_s    = {(WIDTH+1){1'b0}};
          quo_next_s    = abs_a_s;
          dvs_next_s    = abs_b_s;
          count_next_s  = {CNT_W{1'b0}};
`ifdef DIVIDER_EARLY_OUT_EN
          if (special_s) begin
            result_next_s = early_result_s;
            valid_next_s  = 1'b1;
            state_next_s  = ST_IDLE;
          end else begin
            state_next_s  = ST_RUN;
          end
`else
          state_next_s  = ST_RUN;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        rem_next_s   = ge_s ? diff_s : shifted_s[WIDTH:0];
        quo_next_s   = {quo_r[WIDTH-2:0], ge_s};
        count_next_s = count_r + CNT_ONE;
        if (count_r == CNT_LAST) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FIX: begin
        result_next_s = is_rem_r ? r_fix_s : q_fix_s;
        valid_next_s  = 1'b1;
        state_next_s  = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      rem_r    <= {(WIDTH+1){1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      is_rem_r <= 1'b0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      rem_r    <= rem_next_s;
      quo_r    <= quo_next_s;
      dvs_r    <= dvs_next_s;
      count_r  <= count_next_s;
      is_rem_r <= is_rem_next_s;
      q_neg_r  <= q_neg_next_s;
      r_neg_r  <= r_neg_next_s;
      result_r <= result_next_s;
      valid_r  <= valid_next_s;
      busy_r   <= (state_next_s != ST_IDLE);
    end
  end

  assign bus.busy         = busy_r;
  assign bus.result_valid = valid_r;
  assign bus.result       = result_r;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider (WIDTH=32): latency, sign rules, divide-by-zero, handshake.
module tb_iterative_divider;

  localparam int LAT_FULL = 33;
`ifdef DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  iterative_divider_if #(.WIDTH(32)) bus ();

  iterative_divider #(.WIDTH(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk({tag, " idle timeout"}, 32'(bus.busy), 32'h0);
  endtask

  // One operation: result, edges from accept to valid, busy cycles, single-cycle pulse.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int  i, busy_n, lat_exp;
    bit  seen;
    wait_idle(tag);
    bus.start = 1'b1;
    bus.operation = op;
    bus.operand_a = a;
    bus.operand_b = b;
    tick();
    bus.start = 1'b0;
    bus.operand_a = ~a;
    bus.operand_b = ~b;
    busy_n = 0;
    seen = 1'b0;
    i = 0;
    while (!seen && i < 100) begin
      if (bus.result_valid) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_n++;
        i++;
        tick();
      end
    end
    lat_exp = (EARLY && is_special(op, a, b)) ? 0 : LAT_FULL;
    chk({tag, " valid seen"}, 32'(seen), 32'h1);
    chk({tag, " result"}, bus.result, exp);
    chk({tag, " latency"}, 32'(i), 32'(lat_exp));
    chk({tag, " busy cycles"}, 32'(busy_n), 32'(lat_exp));
    tick();
    chk({tag, " pulse width"}, 32'(bus.result_valid), 32'h0);
  endtask

  initial begin
    int  i, pulses;
    logic [1:0]  op;
    logic [31:0] a, b;

    bus.start = 1'b0;
    bus.operation = 2'b00;
    bus.operand_a = 32'h0;
    bus.operand_b = 32'h0;
    repeat (3) tick();
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset valid", 32'(bus.result_valid), 32'h0);
    chk("reset result", bus.result, 32'h0);
    rst = 1'b0;
    tick();

    run_op("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14);
    run_op("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2);
    run_op("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("REM 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
    run_op("DIV -7/-2", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3);
    run_op("REM -8/2", 2'b10, 32'hFFFF_FFF8, 32'd2, 32'h0);
    run_op("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_op("DIVU max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run_op("DIVU 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("DIV -5/0", 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run_op("REM -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run_op("REMU 5/0", 2'b11, 32'd5, 32'd0, 32'd5);

    // Reset ten cycles into an operation discards it.
    wait_idle("reset mid-op");
    bus.start = 1'b1;
    bus.operation = 2'b01;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("mid-op busy before reset", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    tick();
    chk("mid-op reset busy", 32'(bus.busy), 32'h0);
    chk("mid-op reset valid", 32'(bus.result_valid), 32'h0);
    chk("mid-op reset result", bus.result, 32'h0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.result_valid) pulses++;
    end
    chk("mid-op no late pulse", 32'(pulses), 32'h0);

    // Start held high through busy with changing operands, then back-to-back start.
    bus.start = 1'b1;
    bus.operation = 2'b01;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd7;
    tick();
    i = 0;
    while (!bus.result_valid && i < 100) begin
      if (i < 20) begin
        bus.operation = 2'($urandom_range(0, 3));
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      i++;
      tick();
    end
    chk("held start latency", 32'(i), 32'(LAT_FULL));
    chk("held start result", bus.result, 32'd14);
    bus.start = 1'b1;
    bus.operation = 2'b11;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd7;
    tick();
    bus.start = 1'b0;
    chk("b2b accepted busy", 32'(bus.busy), 32'h1);
    chk("b2b valid cleared", 32'(bus.result_valid), 32'h0);
    i = 0;
    while (!bus.result_valid && i < 100) begin
      i++;
      tick();
    end
    chk("b2b latency", 32'(i), 32'(LAT_FULL));
    chk("b2b result", bus.result, 32'd2);
    tick();

    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      run_op("random", op, a, b, ref_div(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
